// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_pkg
//  Description : Shared types and constants for the multi-channel handshake
//                sequencer: state encoding, error cause codes and a helper
//                that sizes the per-channel dwell counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fsm_pkg;

    typedef enum logic [2:0] {
        STATE_IDLE  = 3'd0,
        STATE_1     = 3'd1,
        STATE_2     = 3'd2,
        STATE_3     = 3'd3,
        STATE_ERROR = 3'd4
    } state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_IDLE = 3'd1;
    localparam logic [2:0] ERR_BAD_S1   = 3'd2;
    localparam logic [2:0] ERR_BAD_S2   = 3'd3;
    localparam logic [2:0] ERR_BAD_S3   = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd5;

    // Dwell counter must hold 0..TIMEOUT-1; never narrower than one bit.
    function automatic int dwell_width(input int timeout);
        int w;
        w = (timeout > 0) ? $clog2(timeout + 1) : 1;
        return (w < 1) ? 1 : w;
    endfunction

endpackage : fsm_pkg
`default_nettype wire

// File: rtl/fsm_ch_core.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_ch_core
//  Description : One channel of the handshake sequencer. Holds the state
//                register, the dwell counter used for the stay-too-long
//                timeout, the latched error cause and a saturating count of
//                ERROR entries. Outputs are Moore-decoded from the state.
//  Ports       : clk, n_rst (sync, active-low), en (0 freezes channel),
//                clr (soft clear), i1..i4 (conditions),
//                n_o1/o2/o3/o4 (actuators), err, err_code[2:0],
//                err_cnt[CNT_W-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_ch_core
    import fsm_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             clr,
    input  logic             i1,
    input  logic             i2,
    input  logic             i3,
    input  logic             i4,
    output logic             n_o1,
    output logic             o2,
    output logic             o3,
    output logic             o4,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int DW = dwell_width(TIMEOUT);
    localparam logic [DW-1:0] DWELL_LAST = DW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           r_state;
    logic [DW-1:0]    r_dwell;
    logic [2:0]       r_code;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_next;
    logic [2:0]       w_cause;
    logic             w_timed;
    logic             w_self;

    // ------------------------------------------------------------------
    // Next-state selection
    // ------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        w_cause = ERR_NONE;
        w_timed = 1'b0;
        case (r_state)
            STATE_IDLE: begin
                if (i1 && i2)             w_next = STATE_1;
                else if (i1 && !i2 && i3) w_next = STATE_2;
                else if (!i1)             w_next = STATE_IDLE;
                else begin
                    w_next  = STATE_ERROR;
                    w_cause = ERR_BAD_IDLE;
                end
            end
            STATE_1: begin
                w_timed = 1'b1;
                if (!i2)                  w_next = STATE_1;
                else if (i3)              w_next = STATE_2;
                else if (i4)              w_next = STATE_3;
                else begin
                    w_next  = STATE_ERROR;
                    w_cause = ERR_BAD_S1;
                end
            end
            STATE_2: begin
                w_timed = 1'b1;
                if (i3)                   w_next = STATE_2;
                else if (i4)              w_next = STATE_3;
                else begin
                    w_next  = STATE_ERROR;
                    w_cause = ERR_BAD_S2;
                end
            end
            STATE_3: begin
                w_timed = 1'b1;
                if (!i1)                  w_next = STATE_IDLE;
                else if (!i2)             w_next = STATE_3;
                else begin
                    w_next  = STATE_ERROR;
                    w_cause = ERR_BAD_S3;
                end
            end
            STATE_ERROR: begin
                if (!i1)                  w_next = STATE_IDLE;
                else                      w_next = STATE_ERROR;
            end
            default:                      w_next = STATE_IDLE;
        endcase

        w_self = (w_next == r_state);

        // Timeout only replaces a self-loop, so a legal exit always wins.
        if ((TIMEOUT > 0) && w_timed && w_self && (r_dwell == DWELL_LAST)) begin
            w_next  = STATE_ERROR;
            w_cause = ERR_TIMEOUT;
            w_self  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State, dwell, cause and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= STATE_IDLE;
            r_dwell <= '0;
            r_code  <= ERR_NONE;
            r_cnt   <= '0;
        end else if (clr) begin
            r_state <= STATE_IDLE;
            r_dwell <= '0;
            r_code  <= ERR_NONE;
            r_cnt   <= '0;
        end else if (en) begin
            r_state <= w_next;

            if ((TIMEOUT > 0) && w_timed && w_self)
                r_dwell <= r_dwell + 1'b1;
            else
                r_dwell <= '0;

            // Cause is captured on entry, held during ERROR, dropped on exit.
            if (w_next == STATE_ERROR) begin
                if (r_state != STATE_ERROR) begin
                    r_code <= w_cause;
                    if (r_cnt != {CNT_W{1'b1}})
                        r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_code <= ERR_NONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        n_o1 = 1'b1;
        o2   = 1'b0;
        o3   = 1'b0;
        o4   = 1'b0;
        err  = 1'b0;
        case (r_state)
            STATE_1: begin
                n_o1 = 1'b0;
                o2   = 1'b1;
            end
            STATE_2: begin
                o2 = 1'b1;
                o3 = 1'b1;
            end
            STATE_3:     o4  = 1'b1;
            STATE_ERROR: err = 1'b1;
            default: ;
        endcase
    end

    assign err_code = r_code;
    assign err_cnt  = r_cnt;

endmodule : fsm_ch_core
`default_nettype wire

// File: rtl/fsm_multi.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_multi
//  Description : NUM_CH independent handshake sequencer channels with dwell
//                timeout, enable, soft clear, latched error cause, saturating
//                error counter and an aggregate error flag.
//  Ports       : clk, n_rst (sync, active-low), en/clr/i1..i4 [NUM_CH],
//                n_o1/o2/o3/o4/err [NUM_CH], err_code [3*NUM_CH],
//                err_cnt [CNT_W*NUM_CH], any_err
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_multi
    import fsm_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       clr,
    input  logic [NUM_CH-1:0]       i1,
    input  logic [NUM_CH-1:0]       i2,
    input  logic [NUM_CH-1:0]       i3,
    input  logic [NUM_CH-1:0]       i4,
    output logic [NUM_CH-1:0]       n_o1,
    output logic [NUM_CH-1:0]       o2,
    output logic [NUM_CH-1:0]       o3,
    output logic [NUM_CH-1:0]       o4,
    output logic [NUM_CH-1:0]       err,
    output logic [3*NUM_CH-1:0]     err_code,
    output logic [CNT_W*NUM_CH-1:0] err_cnt,
    output logic                    any_err
);

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            fsm_ch_core #(
                .TIMEOUT (TIMEOUT),
                .CNT_W   (CNT_W)
            ) u_core (
                .clk      (clk),
                .n_rst    (n_rst),
                .en       (en[k]),
                .clr      (clr[k]),
                .i1       (i1[k]),
                .i2       (i2[k]),
                .i3       (i3[k]),
                .i4       (i4[k]),
                .n_o1     (n_o1[k]),
                .o2       (o2[k]),
                .o3       (o3[k]),
                .o4       (o4[k]),
                .err      (err[k]),
                .err_code (err_code[3*k +: 3]),
                .err_cnt  (err_cnt[CNT_W*k +: CNT_W])
            );
        end
    endgenerate

    assign any_err = |err;

endmodule : fsm_multi
`default_nettype wire

// File: tb/tb_fsm_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsm_multi
//  Description : Self-checking bench for fsm_multi (NUM_CH=4, TIMEOUT=4,
//                CNT_W=2). A per-channel behavioural model tracks state,
//                time spent in the state, error cause and error count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_multi;

    localparam int NUM_CH  = 4;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int M_IDLE = 0;
    localparam int M_S1   = 1;
    localparam int M_S2   = 2;
    localparam int M_S3   = 3;
    localparam int M_ERR  = 4;

    logic                    clk = 1'b0;
    logic                    n_rst;
    logic [NUM_CH-1:0]       en, clr, i1, i2, i3, i4;
    logic [NUM_CH-1:0]       n_o1, o2, o3, o4, err;
    logic [3*NUM_CH-1:0]     err_code;
    logic [CNT_W*NUM_CH-1:0] err_cnt;
    logic                    any_err;

    int checks = 0;
    int errors = 0;

    int m_st   [NUM_CH];
    int m_time [NUM_CH];
    int m_code [NUM_CH];
    int m_cnt  [NUM_CH];

    fsm_multi #(
        .NUM_CH  (NUM_CH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (en),
        .clr      (clr),
        .i1       (i1),
        .i2       (i2),
        .i3       (i3),
        .i4       (i4),
        .n_o1     (n_o1),
        .o2       (o2),
        .o3       (o3),
        .o4       (o4),
        .err      (err),
        .err_code (err_code),
        .err_cnt  (err_cnt),
        .any_err  (any_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transition rules as a table lookup; cause 0 means the move is legal.
    task automatic rules(input int st, input bit a, input bit b, input bit c, input bit d,
                         output int nxt, output int cause);
        cause = 0;
        case (st)
            M_IDLE:  if (a && b) nxt = M_S1; else if (a && !b && c) nxt = M_S2;
                     else if (!a) nxt = M_IDLE; else begin nxt = M_ERR; cause = 1; end
            M_S1:    if (!b) nxt = M_S1; else if (c) nxt = M_S2; else if (d) nxt = M_S3;
                     else begin nxt = M_ERR; cause = 2; end
            M_S2:    if (c) nxt = M_S2; else if (d) nxt = M_S3;
                     else begin nxt = M_ERR; cause = 3; end
            M_S3:    if (!a) nxt = M_IDLE; else if (!b) nxt = M_S3;
                     else begin nxt = M_ERR; cause = 4; end
            default: nxt = a ? M_ERR : M_IDLE;
        endcase
    endtask

    task automatic model_update();
        int nxt, cause;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!n_rst || clr[k]) begin
                m_st[k] = M_IDLE; m_time[k] = 1; m_code[k] = 0; m_cnt[k] = 0;
            end else if (en[k]) begin
                rules(m_st[k], i1[k], i2[k], i3[k], i4[k], nxt, cause);
                // m_time counts cycles already spent in the state; the T-th
                // such cycle is the last one allowed.
                if (nxt == m_st[k] && m_st[k] >= M_S1 && m_st[k] <= M_S3 &&
                    m_time[k] == TIMEOUT) begin
                    nxt = M_ERR; cause = 5;
                end
                if (nxt == M_ERR && m_st[k] != M_ERR) begin
                    m_code[k] = cause;
                    if (m_cnt[k] < CNT_MAX) m_cnt[k]++;
                end else if (nxt != M_ERR) begin
                    m_code[k] = 0;
                end
                m_time[k] = (nxt == m_st[k]) ? m_time[k] + 1 : 1;
                m_st[k]   = nxt;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [NUM_CH-1:0]       e_no1, e_o2, e_o3, e_o4, e_err;
        logic [3*NUM_CH-1:0]     e_code;
        logic [CNT_W*NUM_CH-1:0] e_cnt;
        for (int k = 0; k < NUM_CH; k++) begin
            e_no1[k] = (m_st[k] != M_S1);
            e_o2[k]  = (m_st[k] == M_S1) || (m_st[k] == M_S2);
            e_o3[k]  = (m_st[k] == M_S2);
            e_o4[k]  = (m_st[k] == M_S3);
            e_err[k] = (m_st[k] == M_ERR);
            e_code[3*k +: 3]         = 3'(m_code[k]);
            e_cnt[CNT_W*k +: CNT_W]  = CNT_W'(m_cnt[k]);
        end
        chk({tag, ".n_o1"},     32'(n_o1),     32'(e_no1));
        chk({tag, ".o2"},       32'(o2),       32'(e_o2));
        chk({tag, ".o3"},       32'(o3),       32'(e_o3));
        chk({tag, ".o4"},       32'(o4),       32'(e_o4));
        chk({tag, ".err"},      32'(err),      32'(e_err));
        chk({tag, ".err_code"}, 32'(err_code), 32'(e_code));
        chk({tag, ".err_cnt"},  32'(err_cnt),  32'(e_cnt));
        chk({tag, ".any_err"},  32'(any_err),  32'(|e_err));
    endtask

    task automatic step(input string tag = "step");
        @(posedge clk);
        model_update();
        #1;
        check_all(tag);
    endtask

    // p = {i1, i2, i3, i4} for one channel
    task automatic set_in(input int ch, input logic [3:0] p);
        i1[ch] = p[3]; i2[ch] = p[2]; i3[ch] = p[1]; i4[ch] = p[0];
    endtask

    task automatic go(input int ch, input logic [3:0] p, input string tag = "go");
        set_in(ch, p);
        step(tag);
    endtask

    initial begin
        n_rst = 1'b0; en = '1; clr = '0;
        i1 = '0; i2 = '0; i3 = '0; i4 = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_st[k] = M_IDLE; m_time[k] = 1; m_code[k] = 0; m_cnt[k] = 0;
        end

        // Reset
        step("reset0");
        step("reset1");
        chk("reset_n_o1", 32'(n_o1), 32'hF);
        chk("reset_o2_o3_o4_err", 32'({o2, o3, o4, err}), 32'h0);
        n_rst = 1'b1;

        // Happy path on channel 0
        go(0, 4'b1100, "happy_s1");
        chk("happy_s1_n_o1", 32'(n_o1), 32'hE);
        go(0, 4'b1110, "happy_s2");
        chk("happy_s2_o3", 32'(o3), 32'h1);
        go(0, 4'b1101, "happy_s3");
        chk("happy_s3_o4", 32'(o4), 32'h1);
        go(0, 4'b0000, "happy_idle");

        // Error causes on channel 0
        go(0, 4'b1000, "bad_idle");
        chk("bad_idle_code", 32'(err_code[2:0]), 32'd1);
        go(0, 4'b0000, "exit1");
        chk("exit1_code_cnt", 32'({err_code[2:0], err_cnt[1:0]}), {27'd0, 3'd0, 2'd1});
        go(0, 4'b1100); go(0, 4'b1100, "bad_s1");
        chk("bad_s1_code", 32'(err_code[2:0]), 32'd2);
        go(0, 4'b0000);
        go(0, 4'b1100); go(0, 4'b0110); go(0, 4'b1000, "bad_s2");
        chk("bad_s2_code", 32'(err_code[2:0]), 32'd3);
        go(0, 4'b0000);
        go(0, 4'b1100); go(0, 4'b1101); go(0, 4'b1100, "bad_s3");
        chk("bad_s3_code", 32'(err_code[2:0]), 32'd4);
        chk("bad_s3_cnt_sat", 32'(err_cnt[1:0]), 32'd3);
        go(0, 4'b0000);

        // Timeout on channel 1: four cycles in S1 then ERROR
        go(1, 4'b1100, "to_s1");
        for (int n = 0; n < 3; n++) go(1, 4'b1000, "to_hold");
        chk("to_last_in_s1", 32'(o2[1]), 32'd1);
        go(1, 4'b1000, "to_fire");
        chk("to_err", 32'({err[1], err_code[5:3]}), {28'd0, 1'b1, 3'd5});
        go(1, 4'b0000);
        // Legal exit on the fourth cycle beats the timeout
        go(1, 4'b1100);
        for (int n = 0; n < 3; n++) go(1, 4'b1000);
        go(1, 4'b1110, "to_exit");
        chk("to_exit_s2", 32'({err[1], o3[1]}), 32'b01);
        go(1, 4'b0001); go(1, 4'b0000);

        // Enable freeze on channel 2
        go(2, 4'b1010, "en_s2");
        en[2] = 1'b0;
        for (int n = 0; n < 10; n++) go(2, 4'b0000, "en_frozen");
        chk("en_frozen_s2", 32'({err[2], o3[2]}), 32'b01);
        en[2] = 1'b1;
        for (int r = 0; r < 3; r++) begin
            go(2, 4'b1010); go(2, 4'b1000, "en_err");
            if (r < 2) go(2, 4'b0000);
        end
        chk("clr_pre_cnt", 32'(err_cnt[5:4]), 32'd3);
        clr[2] = 1'b1; en[2] = 1'b0;
        step("clr");
        chk("clr_post", 32'({err[2], err_code[8:6], err_cnt[5:4]}), 32'd0);
        clr[2] = 1'b0; en[2] = 1'b1;
        go(2, 4'b0000);

        // Saturation on channel 3
        for (int r = 0; r < 5; r++) begin
            go(3, 4'b1000, "sat_err"); go(3, 4'b0000, "sat_exit");
        end
        chk("sat_cnt", 32'(err_cnt[7:6]), 32'd3);
        go(3, 4'b1000);
        for (int n = 0; n < 20; n++) step("sat_stay");
        chk("sat_stay_cnt", 32'({err[3], err_cnt[7:6]}), 32'b111);
        go(3, 4'b0000);

        // Reset mid-operation
        go(1, 4'b1000);
        go(0, 4'b1100); go(0, 4'b1110); go(0, 4'b1101); go(0, 4'b1000, "mid_s3");
        n_rst = 1'b0;
        #2;
        check_all("rst_before_edge");
        chk("rst_before_edge_o4", 32'(o4[0]), 32'd1);
        step("rst_edge");
        chk("rst_edge_idle", 32'({any_err, o4, err_cnt}), 32'd0);
        n_rst = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            n_rst = ($urandom_range(0, 59) != 0);
            en    = NUM_CH'($urandom_range(0, 15) | $urandom_range(0, 15));
            clr   = NUM_CH'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            i1    = NUM_CH'($urandom_range(0, 15));
            i2    = NUM_CH'($urandom_range(0, 15));
            i3    = NUM_CH'($urandom_range(0, 15));
            i4    = NUM_CH'($urandom_range(0, 15));
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fsm_multi
`default_nettype wire
